// File: rtl/dmem_bus_demux.sv
// ----------------------------------------------------------------------------
// dmem_bus_demux
//
// Splits the core's single data-memory request channel into two target
// channels: target 0 (data RAM) and target 1 (MMIO / peripheral region).
// The target is picked once, at acceptance, by address decode
// ((addr & SEL_MASK) == SEL_MATCH selects target 1). One transaction is in
// flight at a time. The request payload is registered and broadcast to both
// targets, and the selected target's response is registered back to the
// initiator as a one-cycle pulse.
//
// Transaction flow: IDLE -> REQ -> RSP -> DONE -> IDLE.
// This gives at most one transaction every 4 cycles.
//
// Optional build macro: DMEM_DEMUX_TIMEOUT_EN
//   When defined, the block adds the rsp_err output and an abort counter.
//   If a transaction spends TIMEOUT_CYCLES cycles in REQ/RSP, it is aborted
//   with rsp_rdata = 0 and rsp_err = 1.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   req_valid/ready/addr/we/wdata/wstrb   initiator request channel
//   rsp_valid      one-cycle response pulse (no backpressure)
//   rsp_rdata      response read data (0 for writes), held until next response
//   tgt_valid[1:0] per-target request valid (one-hot or zero)
//   tgt_ready[1:0] per-target request ready
//   tgt_addr/we/wdata/wstrb  registered payload broadcast to both targets
//   tgt_rsp_valid[1:0]       per-target response valid
//   tgt_rsp_rdata  target 0 data in [WIDTH-1:0], target 1 in [2*WIDTH-1:WIDTH]
//   rsp_err        (DMEM_DEMUX_TIMEOUT_EN only) response was a timeout abort
// ----------------------------------------------------------------------------
module dmem_bus_demux #(
    parameter int                WIDTH          = 64,
    parameter int                ADDR_WIDTH     = 64,
    parameter logic [ADDR_WIDTH-1:0] SEL_MASK   = 64'hFFFF_FFFF_F000_0000,
    parameter logic [ADDR_WIDTH-1:0] SEL_MATCH  = 64'h0000_0000_1000_0000,
    parameter int                TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [WIDTH-1:0]      req_wdata,
    input  logic [WIDTH/8-1:0]    req_wstrb,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic [1:0]            tgt_valid,
    input  logic [1:0]            tgt_ready,
    output logic [ADDR_WIDTH-1:0] tgt_addr,
    output logic                  tgt_we,
    output logic [WIDTH-1:0]      tgt_wdata,
    output logic [WIDTH/8-1:0]    tgt_wstrb,
    input  logic [1:0]            tgt_rsp_valid,
    input  logic [2*WIDTH-1:0]    tgt_rsp_rdata
`ifdef DMEM_DEMUX_TIMEOUT_EN
    ,
    output logic                  rsp_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Address decode: 1 selects the MMIO target.
    function automatic logic decode(input logic [ADDR_WIDTH-1:0] addr);
        return ((addr & SEL_MASK) == SEL_MATCH);
    endfunction

    state_t                  state_r;
    state_t                  next_s;

    logic                    req_ready_r;
    logic                    rsp_valid_r;
    logic [WIDTH-1:0]        rsp_rdata_r;
    logic [1:0]              tgt_valid_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    we_r;
    logic [WIDTH-1:0]        wdata_r;
    logic [WIDTH/8-1:0]      wstrb_r;
    logic                    sel_r;

    logic                    ready_n_s;
    logic                    rvalid_n_s;
    logic [WIDTH-1:0]        rdata_n_s;
    logic [1:0]              tvalid_n_s;
    logic                    capture_s;
    logic [1:0]              sel_onehot_s;
    logic                    sel_rsp_s;
    logic                    abort_s;

    assign sel_onehot_s = sel_r ? 2'b10 : 2'b01;
    assign sel_rsp_s    = tgt_rsp_valid[sel_r];

`ifdef DMEM_DEMUX_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             rsp_err_r;

    assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    // Abort on the cycle whose increment would reach the threshold, so the
    // transaction spends exactly TIMEOUT_CYCLES cycles in REQ/RSP.
    assign abort_s   = ((state_r == REQ) || (state_r == RSP)) &&
                       (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES));

    // Timeout counter: cleared on acceptance, counts while waiting on a target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (capture_s) begin
            cnt_r <= '0;
        end else if ((state_r == REQ) || (state_r == RSP)) begin
            cnt_r <= cnt_inc_s;
        end
    end

    // Error flag: set on abort, cleared by a normal response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err_r <= 1'b0;
        end else if (abort_s) begin
            rsp_err_r <= 1'b1;
        end else if ((state_r == RSP) && sel_rsp_s) begin
            rsp_err_r <= 1'b0;
        end
    end

    assign rsp_err = rsp_err_r;
`else
    logic unused_timeout_s;

    assign abort_s          = 1'b0;
    // Keeps the threshold parameter referenced when the timeout is compiled out.
    assign unused_timeout_s = (TIMEOUT_CYCLES != 32'sd0);
`endif

    // Next-state and next-output decode for the transaction FSM.
    always_comb begin
        next_s     = state_r;
        ready_n_s  = 1'b0;
        rvalid_n_s = 1'b0;
        rdata_n_s  = rsp_rdata_r;
        tvalid_n_s = 2'b00;
        capture_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    next_s     = REQ;
                    capture_s  = 1'b1;
                    tvalid_n_s = decode(req_addr) ? 2'b10 : 2'b01;
                end else begin
                    ready_n_s  = 1'b1;
                end
            end
            REQ: begin
                if (abort_s) begin
                    next_s     = DONE;
                    rvalid_n_s = 1'b1;
                    rdata_n_s  = '0;
                end else if (tgt_ready[sel_r]) begin
                    // Handshake done; a response in this same cycle is ignored.
                    next_s     = RSP;
                end else begin
                    tvalid_n_s = sel_onehot_s;
                end
            end
            RSP: begin
                if (abort_s) begin
                    next_s     = DONE;
                    rvalid_n_s = 1'b1;
                    rdata_n_s  = '0;
                end else if (sel_rsp_s) begin
                    next_s     = DONE;
                    rvalid_n_s = 1'b1;
                    if (we_r) begin
                        rdata_n_s = '0;
                    end else if (sel_r) begin
                        rdata_n_s = tgt_rsp_rdata[2*WIDTH-1:WIDTH];
                    end else begin
                        rdata_n_s = tgt_rsp_rdata[WIDTH-1:0];
                    end
                end else begin
                    next_s     = RSP;
                end
            end
            DONE: begin
                next_s    = IDLE;
                ready_n_s = 1'b1;
            end
            default: begin
                next_s    = IDLE;
                ready_n_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            tgt_valid_r <= 2'b00;
        end else begin
            state_r     <= next_s;
            req_ready_r <= ready_n_s;
            rsp_valid_r <= rvalid_n_s;
            rsp_rdata_r <= rdata_n_s;
            tgt_valid_r <= tvalid_n_s;
        end
    end

    // Request payload holding registers, loaded only at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= '0;
            we_r    <= 1'b0;
            wdata_r <= '0;
            wstrb_r <= '0;
            sel_r   <= 1'b0;
        end else if (capture_s) begin
            addr_r  <= req_addr;
            we_r    <= req_we;
            wdata_r <= req_wdata;
            wstrb_r <= req_wstrb;
            sel_r   <= decode(req_addr);
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign tgt_valid = tgt_valid_r;
    assign tgt_addr  = addr_r;
    assign tgt_we    = we_r;
    assign tgt_wdata = wdata_r;
    assign tgt_wstrb = wstrb_r;

endmodule

// File: doc/dmem_bus_demux.md
Name: dmem_bus_demux

Overview:
Splits the core's single data-memory request channel into two target channels: target 0 is data RAM and target 1 is an MMIO/peripheral region. It selects the target by address decode and holds one transaction in flight. It then routes the selected target's response back to the initiator. It is the one-to-two counterpart of the operand/result select muxes, with valid/ready handshaking and a registered request stage.

Parameters:
WIDTH, 64, data width of wdata/rdata.
ADDR_WIDTH, 64, address width.
SEL_MASK, 64'hFFFF_FFFF_F000_0000, address bits compared for decode.
SEL_MATCH, 64'h0000_0000_1000_0000, (addr & SEL_MASK) == SEL_MATCH selects target 1; otherwise target 0.
TIMEOUT_CYCLES, 255, abort threshold; used only with DMEM_DEMUX_TIMEOUT_EN.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  initiator request valid.
req_ready  out  1  initiator request accepted when req_valid & req_ready.
req_addr  in  ADDR_WIDTH  request address.
req_we  in  1  1 = write, 0 = read.
req_wdata  in  WIDTH  write data.
req_wstrb  in  WIDTH/8  byte write strobes.
rsp_valid  out  1  one-cycle response pulse to initiator; no backpressure.
rsp_rdata  out  WIDTH  read data; 0 for writes.
tgt_valid  out  2  per-target request valid; at most one bit set.
tgt_ready  in  2  per-target request ready.
tgt_addr  out  ADDR_WIDTH  registered address, broadcast to both targets.
tgt_we  out  1  registered write enable, broadcast.
tgt_wdata  out  WIDTH  registered write data, broadcast.
tgt_wstrb  out  WIDTH/8  registered strobes, broadcast.
tgt_rsp_valid  in  2  per-target response valid; targets respond to reads and writes.
tgt_rsp_rdata  in  2*WIDTH  target 0 in [WIDTH-1:0], target 1 in [2*WIDTH-1:WIDTH].

Behaviour:
- Reset: state IDLE; req_ready=0 while reset is asserted, then 1 in IDLE. All other outputs and holding registers are 0. Reset mid-transaction drops the in-flight transaction; no response is issued.
- State IDLE: req_ready=1.
  - On req_valid, latch addr/we/wdata/wstrb and sel = decode(req_addr), then go to REQ.
- State REQ: tgt_valid[sel]=1 and the other bit 0; payload is held stable.
  - On tgt_ready[sel]=1, drop tgt_valid the next cycle and go to RSP.
- State RSP: wait for tgt_rsp_valid[sel].
  - When it arrives, register the data (or 0 if write) into rsp_rdata and go to DONE.
- State DONE: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata holds its value until the next response.
- req_ready=0 in REQ, RSP and DONE, so one transaction is outstanding at most. Back-to-back throughput is one transaction per 4 cycles minimum.
- Latency:
  - Request accepted at edge N; tgt_valid is high in cycle N+1.
  - With tgt_ready=1 immediately and the response in the cycle after the request is accepted, rsp_valid is high in cycle N+3.
- Response rules:
  - tgt_rsp_valid from the non-selected target, or in any state other than RSP, is ignored.
  - tgt_rsp_valid[sel] arriving in the same cycle as tgt_ready[sel] is also ignored; the response is expected after the handshake.
- Decode is evaluated once at acceptance; address wrap has no special case.

Optional Feature:
DMEM_DEMUX_TIMEOUT_EN
- Defined:
  - Adds output port rsp_err (1 bit, reset 0) and an 8+ bit counter. The counter clears on acceptance and increments every cycle in REQ or RSP.
  - When the counter reaches TIMEOUT_CYCLES: tgt_valid drops, and the block goes to DONE with rsp_rdata=0 and rsp_err=1.
  - rsp_err is 0 on normal responses and is only meaningful while rsp_valid=1.
  - A late response from the aborted target is ignored.
- Undefined: the rsp_err port and the counter are absent, and the block waits indefinitely.

Test Plan:
1. Read to 64'h0000_0000_0000_0100, target 0 ready immediately, responds with 64'hDEAD_BEEF_0123_4567 one cycle later -> tgt_valid=2'b01 for one cycle; rsp_valid for one cycle with that data, 3 cycles after acceptance; tgt_valid[1] is never set.
2. Write to 64'h0000_0000_1000_0008, wdata 64'h55, wstrb 8'h01, target 1 holds ready low for 5 cycles -> tgt_valid=2'b10 held with a stable payload for 6 cycles; rsp_rdata=0 on response.
3. req_valid held high for back-to-back reads to targets 0 then 1 -> second request accepted only after the first rsp_valid; no overlap of tgt_valid bits.
4. Target 0 asserts tgt_rsp_valid with data 64'h1 while the transaction is on target 1, and also while IDLE -> ignored; the final rsp_rdata equals target 1's data.
5. Assert reset in RSP -> all outputs 0 asynchronously; no rsp_valid; the next request completes normally.
6. (DMEM_DEMUX_TIMEOUT_EN, TIMEOUT_CYCLES=10) target 1 never ready -> rsp_valid with rsp_err=1 and rsp_rdata=0 after 10 cycles in REQ; tgt_valid deasserted.
